// File: rtl/maze_walker.sv
// maze_walker: player-position engine for the maze game.
// It accepts one-step move requests, checks each target tile against the wall
// bitmap, commits legal moves and flags arrival at the exit tile.
module maze_walker #(
  parameter int START_X = 1,
  parameter int START_Y = 1,
  parameter int EXIT_X  = 62,
  parameter int EXIT_Y  = 46
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [3071:0] C_map,
  input  logic          level_load,
  input  logic          move_valid,
  input  logic [1:0]    move_dir,
  output logic          move_ready,
  output logic          resp_valid,
  output logic          resp_blocked,
  output logic [5:0]    pos_x,
  output logic [5:0]    pos_y,
  output logic          at_exit,
  output logic [15:0]   move_count
);

  localparam logic [5:0] START_X6 = 6'(START_X);
  localparam logic [5:0] START_Y6 = 6'(START_Y);
  localparam logic [5:0] EXIT_X6  = 6'(EXIT_X);
  localparam logic [5:0] EXIT_Y6  = 6'(EXIT_Y);
  localparam logic [5:0] MAX_X    = 6'd63;
  localparam logic [5:0] MAX_Y    = 6'd47;

  typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

  state_t        state_q, state_d;
  logic [5:0]    tgt_x_q, tgt_x_d;
  logic [5:0]    tgt_y_q, tgt_y_d;
  logic          oob_q, oob_d;
  logic          blocked_q, blocked_d;
  logic [5:0]    pos_x_q, pos_x_d;
  logic [5:0]    pos_y_q, pos_y_d;
  logic          at_exit_q, at_exit_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_blocked_q, resp_blocked_d;
  logic          handshake;
  logic [11:0]   map_idx;
  logic [12:0]   step_res;

  // One step from (x,y) in direction dir. Returns {oob, tx, ty}; an
  // out-of-bounds step leaves the target on the current tile (no wrap).
  function automatic logic [12:0] step(input logic [5:0] x, input logic [5:0] y,
                                       input logic [1:0] dir);
    logic       oob;
    logic [5:0] tx;
    logic [5:0] ty;
    oob = 1'b0;
    tx  = x;
    ty  = y;
    case (dir)
      2'b00: if (y == 6'd0)  oob = 1'b1; else ty = y - 6'd1;
      2'b01: if (y == MAX_Y) oob = 1'b1; else ty = y + 6'd1;
      2'b10: if (x == 6'd0)  oob = 1'b1; else tx = x - 6'd1;
      default: if (x == MAX_X) oob = 1'b1; else tx = x + 6'd1;
    endcase
    return {oob, tx, ty};
  endfunction

  // Move counter that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign handshake = move_valid & move_ready;
  assign step_res  = step(pos_x_q, pos_y_q, move_dir);
  // Bit 64*y + (63-x): with 6-bit x, 63-x is simply ~x.
  assign map_idx   = {tgt_y_q, ~tgt_x_q};

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; a level load always returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (level_load) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (handshake) state_d = CHECK;
        CHECK:   state_d = RESP;
        RESP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM output: ready only in IDLE and never while a level load is pulsing.
  always_comb begin
    move_ready = (state_q == IDLE) && !level_load;
  end

  // Datapath next state: target capture, map check, commit.
  always_comb begin
    tgt_x_d        = tgt_x_q;
    tgt_y_d        = tgt_y_q;
    oob_d          = oob_q;
    blocked_d      = blocked_q;
    pos_x_d        = pos_x_q;
    pos_y_d        = pos_y_q;
    at_exit_d      = at_exit_q;
    cnt_d          = cnt_q;
    resp_valid_d   = 1'b0;
    resp_blocked_d = resp_blocked_q;
    if (level_load) begin
      pos_x_d        = START_X6;
      pos_y_d        = START_Y6;
      at_exit_d      = 1'b0;
      cnt_d          = 16'd0;
      resp_blocked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (handshake) begin
            oob_d   = step_res[12];
            tgt_x_d = step_res[11:6];
            tgt_y_d = step_res[5:0];
          end
        end
        CHECK: begin
          // The only cycle in which the bitmap is sampled.
          blocked_d      = oob_q | C_map[map_idx] | at_exit_q;
          resp_valid_d   = 1'b1;
          resp_blocked_d = blocked_d;
        end
        RESP: begin
          if (!blocked_q) begin
            pos_x_d   = tgt_x_q;
            pos_y_d   = tgt_y_q;
            cnt_d     = sat_inc(cnt_q);
            at_exit_d = (tgt_x_q == EXIT_X6) && (tgt_y_q == EXIT_Y6);
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers; reset clears every latch.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      tgt_x_q        <= START_X6;
      tgt_y_q        <= START_Y6;
      oob_q          <= 1'b0;
      blocked_q      <= 1'b0;
      pos_x_q        <= START_X6;
      pos_y_q        <= START_Y6;
      at_exit_q      <= 1'b0;
      cnt_q          <= 16'd0;
      resp_valid_q   <= 1'b0;
      resp_blocked_q <= 1'b0;
    end else begin
      tgt_x_q        <= tgt_x_d;
      tgt_y_q        <= tgt_y_d;
      oob_q          <= oob_d;
      blocked_q      <= blocked_d;
      pos_x_q        <= pos_x_d;
      pos_y_q        <= pos_y_d;
      at_exit_q      <= at_exit_d;
      cnt_q          <= cnt_d;
      resp_valid_q   <= resp_valid_d;
      resp_blocked_q <= resp_blocked_d;
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_blocked = resp_blocked_q;
  assign pos_x        = pos_x_q;
  assign pos_y        = pos_y_q;
  assign at_exit      = at_exit_q;
  assign move_count   = cnt_q;

endmodule
